// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier: one recoded digit per cycle, signed or
// unsigned operands selected per operation, exact 2*WIDTH-bit product.
module booth_mult_r4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 6;
  localparam int CW = $clog2(WIDTH / 2 + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [EW-1:0]         mcand;
  logic [EW-1:0]         mq;
  logic                  prev;
  logic                  mode_q;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         last;

  logic [EW-1:0]         a_ext;
  logic [EW-1:0]         b_ext;
  logic signed [AW-1:0]  m_se;
  logic signed [AW-1:0]  pp;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  acc_next;

  assign a_ext = mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  assign m_se  = {{(AW-EW){mcand[EW-1]}}, mcand};

  always_comb begin
    pp = '0;
    case ({mq[1:0], prev})
      3'b001, 3'b010: pp = m_se;
      3'b011:         pp = m_se <<< 1;
      3'b100:         pp = -(m_se <<< 1);
      3'b101, 3'b110: pp = -m_se;
      default:        pp = '0;
    endcase
  end

  // Digits enter WIDTH+2 bits up so the unsigned pass (one extra digit) keeps
  // every low bit; the signed pass ends with the product two bits higher.
  assign acc_sum  = acc + (pp <<< (WIDTH + 2));
  assign acc_next = acc_sum >>> 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mq      <= '0;
      prev    <= 1'b0;
      mode_q  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      last    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a_ext;
            mq     <= b_ext;
            prev   <= 1'b0;
            mode_q <= mode;
            acc    <= '0;
            cnt    <= '0;
            last   <= mode ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc  <= acc_next;
          mq   <= {{2{mq[EW-1]}}, mq[EW-1:2]};
          prev <= mq[1];
          cnt  <= cnt + 1'b1;
          if (cnt == last) begin
            product <= (2 * WIDTH)'(mode_q ? (acc_next >>> 2) : acc_next);
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH=8 and WIDTH=16 against a
// plain integer-multiply reference.
module tb_booth_mult_r4;

  logic        clk;
  logic        rst;
  logic        start8, mode8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start16, mode16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mult_r4 #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_r4 #(.WIDTH(16)) d16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s16, input bit st, input bit m,
                       input logic [15:0] x, input logic [15:0] y);
    if (s16) begin
      start16 = st; mode16 = m; a16 = x; b16 = y;
    end else begin
      start8 = st; mode8 = m; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  function automatic bit get_busy(input bit s16);
    return s16 ? busy16 : busy8;
  endfunction

  function automatic bit get_done(input bit s16);
    return s16 ? done16 : done8;
  endfunction

  function automatic logic [31:0] get_prod(input bit s16);
    return s16 ? prod16 : {16'h0, prod8};
  endfunction

  function automatic int iters(input bit s16, input bit m);
    return (s16 ? 8 : 4) + (m ? 0 : 1);
  endfunction

  function automatic logic [31:0] ref_mul(input bit s16, input bit m,
                                          input logic [15:0] x, input logic [15:0] y);
    longint xa, ya, p;
    if (s16) begin
      xa = m ? longint'($signed(x)) : longint'(x);
      ya = m ? longint'($signed(y)) : longint'(y);
    end else begin
      xa = m ? longint'($signed(x[7:0])) : longint'(x[7:0]);
      ya = m ? longint'($signed(y[7:0])) : longint'(y[7:0]);
    end
    p = xa * ya;
    return s16 ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  // One full operation; poke >= 0 pulses start with 7x7 during CALC.
  task automatic do_op(input bit s16, input bit m, input logic [15:0] x,
                       input logic [15:0] y, input logic [31:0] exp,
                       input int poke, input string tag);
    int it;
    int cyc;
    int bc;
    it  = iters(s16, m);
    cyc = 0;
    bc  = 0;
    @(negedge clk);
    drive(s16, 1'b1, m, x, y);
    @(negedge clk);
    drive(s16, 1'b0, ~m, 16'($urandom), 16'($urandom));
    while (!get_done(s16) && cyc < 200) begin
      if (get_busy(s16)) bc++;
      if (poke >= 0 && cyc == poke) drive(s16, 1'b1, m, 16'd7, 16'd7);
      else if (poke >= 0 && cyc == poke + 1) drive(s16, 1'b0, m, 16'd0, 16'd0);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(it));
    chk({tag, " busy_cycles"}, 32'(bc), 32'(it));
    chk({tag, " product"}, get_prod(s16), exp);
    chk({tag, " busy_at_done"}, 32'(get_busy(s16)), 32'd0);
    @(negedge clk);
    chk({tag, " done_pulse_width"}, 32'(get_done(s16)), 32'd0);
  endtask

  task automatic quiet_check(input bit s16, input int n, input string tag);
    int dc;
    int bc;
    dc = 0;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      if (get_done(s16)) dc++;
      if (get_busy(s16)) bc++;
      @(negedge clk);
    end
    chk({tag, " no_done"}, 32'(dc), 32'd0);
    chk({tag, " no_busy"}, 32'(bc), 32'd0);
  endtask

  task automatic b2b(input bit s16, input logic [15:0] x1, input logic [15:0] y1,
                     input logic [15:0] x2, input logic [15:0] y2, input string tag);
    int it;
    int cyc;
    it  = iters(s16, 1'b1);
    cyc = 0;
    @(negedge clk);
    drive(s16, 1'b1, 1'b1, x1, y1);
    @(negedge clk);
    drive(s16, 1'b1, 1'b1, x2, y2);
    while (!get_done(s16) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " first_product"}, get_prod(s16), ref_mul(s16, 1'b1, x1, y1));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) drive(s16, 1'b0, 1'b1, 16'd0, 16'd0);
    end while (!get_done(s16) && cyc < 200);
    chk({tag, " done_gap"}, 32'(cyc), 32'(it + 1));
    chk({tag, " second_product"}, get_prod(s16), ref_mul(s16, 1'b1, x2, y2));
    @(negedge clk);
  endtask

  task automatic rst_mid(input bit s16, input string tag);
    @(negedge clk);
    drive(s16, 1'b1, 1'b1, 16'h0055, 16'h0033);
    @(negedge clk);
    drive(s16, 1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, " busy_after_rst"}, 32'(get_busy(s16)), 32'd0);
    chk({tag, " done_after_rst"}, 32'(get_done(s16)), 32'd0);
    chk({tag, " product_after_rst"}, get_prod(s16), 32'd0);
    quiet_check(s16, iters(s16, 1'b1) + 3, {tag, " aborted"});
  endtask

  logic [15:0] corner8[5];
  logic [15:0] corner16[5];

  initial begin
    bit          s16;
    bit          m;
    logic [15:0] x;
    logic [15:0] y;

    corner8  = '{16'h0000, 16'h0001, 16'h00FF, 16'h0080, 16'h007F};
    corner16 = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("w8 reset busy", 32'(busy8), 32'd0);
    chk("w8 reset done", 32'(done8), 32'd0);
    chk("w8 reset product", {16'h0, prod8}, 32'd0);
    chk("w16 reset busy", 32'(busy16), 32'd0);
    chk("w16 reset product", prod16, 32'd0);
    rst = 1'b0;

    // WIDTH=8 directed scenarios
    do_op(1'b0, 1'b1, 16'h00DA, 16'h00B7, 32'h0AD6, -1, "w8 neg38xneg73");
    do_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, -1, "w8 ffxff");
    do_op(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h4000, -1, "w8 minxmin");
    do_op(1'b0, 1'b1, 16'h0080, 16'h007F, 32'hC080, -1, "w8 minxmax");
    do_op(1'b0, 1'b1, 16'h0003, 16'h0005, 32'h000F, 1, "w8 start_in_calc");
    quiet_check(1'b0, 10, "w8 dropped_request");
    do_op(1'b0, 1'b0, 16'h0000, 16'h00A5, 32'h0000, -1, "w8 zero_a");
    do_op(1'b0, 1'b1, 16'h005A, 16'h0000, 32'h0000, -1, "w8 zero_b");
    b2b(1'b0, 16'h0005, 16'h00FD, 16'h0002, 16'h0002, "w8 b2b");
    rst_mid(1'b0, "w8 rst_mid");
    do_op(1'b0, 1'b0, 16'h0012, 16'h0034, 32'h03A8, -1, "w8 after_rst");

    // rst wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0011);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk("w8 rst_over_start busy", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("w8 rst_over_start idle", 32'(busy8), 32'd0);

    // WIDTH=16 directed scenarios
    do_op(1'b1, 1'b1, 16'hFFDA, 16'hFFB7, ref_mul(1'b1, 1'b1, 16'hFFDA, 16'hFFB7), -1, "w16 neg38xneg73");
    do_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1, "w16 ffffxffff");
    do_op(1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000, -1, "w16 minxmin");
    do_op(1'b1, 1'b1, 16'h8000, 16'h7FFF, ref_mul(1'b1, 1'b1, 16'h8000, 16'h7FFF), -1, "w16 minxmax");
    do_op(1'b1, 1'b1, 16'h0003, 16'h0005, 32'h0000000F, 2, "w16 start_in_calc");
    quiet_check(1'b1, 18, "w16 dropped_request");
    b2b(1'b1, 16'h0005, 16'hFFFD, 16'h0002, 16'h0002, "w16 b2b");
    rst_mid(1'b1, "w16 rst_mid");
    do_op(1'b1, 1'b0, 16'h0012, 16'h0034, 32'h000003A8, -1, "w16 after_rst");

    // randomized sweep mixing corner operands and random values
    for (int i = 0; i < 48; i++) begin
      s16 = 1'($urandom_range(0, 1));
      m   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        x = s16 ? corner16[$urandom_range(0, 4)] : corner8[$urandom_range(0, 4)];
      else
        x = 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        y = s16 ? corner16[$urandom_range(0, 4)] : corner8[$urandom_range(0, 4)];
      else
        y = 16'($urandom);
      if (!s16) begin
        x = {8'h00, x[7:0]};
        y = {8'h00, y[7:0]};
      end
      do_op(s16, m, x, y, ref_mul(s16, m, x, y), -1, s16 ? "w16 rand" : "w8 rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4.md
BOOTH_MULT_R4 -- requirements
Module: booth_mult_r4

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; SHALL be even and >= 4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request to begin a multiply; sampled only while busy=0.
REQ-005 mode  in  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start.
REQ-006 a  in  WIDTH  multiplicand; sampled with start.
REQ-007 b  in  WIDTH  multiplier; sampled with start.
REQ-008 busy  out  1  high while a multiply is in progress.
REQ-009 done  out  1  one-cycle pulse when product becomes valid.
REQ-010 product  out  2*WIDTH  result of the last completed multiply.

Function
REQ-011 Algorithm: radix-4 Booth recoding, one recoded digit (2 multiplier bits plus the previous bit) retired per cycle, with partial-product digits in {-2,-1,0,+1,+2} x multiplicand.
REQ-012 Operand extension: multiplicand and multiplier are extended to WIDTH+2 bits, sign-extended if mode=1 and zero-extended if mode=0.
REQ-013 Iteration count: ITER = WIDTH/2 when mode=1 and WIDTH/2+1 when mode=0.
REQ-014 Accumulator: at least 2*WIDTH+4 bits; arithmetic right shift by 2 after every add/subtract; the implicit previous bit is initialised to 0.
REQ-015 FSM states: IDLE, CALC and DONE.
REQ-016 FSM transition IDLE->CALC when start=1.
REQ-017 FSM transition CALC->CALC while the iteration counter is below ITER-1.
REQ-018 FSM transition CALC->DONE after iteration ITER-1.
REQ-019 FSM transition DONE->CALC when start=1; otherwise DONE->IDLE.
REQ-020 Load: on the edge that accepts start, a, b and mode are latched into internal registers, the accumulator is cleared, the counter is cleared and busy goes to 1.
REQ-021 Operand stability: later changes on a, b or mode do not affect the operation in flight.
REQ-022 Latency: if start is accepted at edge t, done=1 and product is valid in the cycle after edge t+ITER; busy=1 for exactly ITER cycles.
REQ-023 done: high only in DONE, for exactly one cycle.
REQ-024 busy: high only in CALC.
REQ-025 product: updated only on the CALC->DONE edge; it then holds until the next completion or reset.
REQ-026 product width: the low 2*WIDTH bits of the exact product, so it is always exact.
REQ-027 Signed boundary: -2^(WIDTH-1) x -2^(WIDTH-1) = 2^(2*WIDTH-2), with no overflow.
REQ-028 Unsigned boundary: (2^WIDTH-1)^2 is exact.
REQ-029 start while busy=1: ignored; no queueing and no effect on the operation in flight.
REQ-030 start in DONE: accepted (back-to-back operation); the next done follows ITER+1 cycles later.
REQ-031 Zero operand (a=0 or b=0): still runs the full ITER cycles; product=0.

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, busy=0, done=0, product=0, internal registers=0.
REQ-033 rst overrides start in the same cycle.
REQ-034 rst mid-operation aborts the multiply with no done pulse; the first start after rst is released behaves as from power-up.

Verification
REQ-035 WIDTH=8, mode=1, a=0xDA (-38), b=0xB7 (-73), start at edge t -> busy for 4 cycles; done at cycle t+5; product=0x0AD6 (2774).
REQ-036 WIDTH=8, mode=0, a=0xFF, b=0xFF -> busy for 5 cycles; product=0xFE01.
REQ-037 WIDTH=8, mode=1, a=0x80, b=0x80 -> product=0x4000; then a=0x80, b=0x7F -> product=0xC080 (-16256).
REQ-038 Start at t with a=3, b=5 (mode=1), start pulsed again with a=7, b=7 during CALC -> single done; product=0x000F; second request dropped.
REQ-039 Back-to-back: start held high through DONE, first op 5x-3 (mode=1), second op 2x2 -> products 0xFFF1 then 0x0004; done pulses separated by 5 cycles.
REQ-040 rst asserted during the second CALC cycle -> busy=0, done never asserts, product=0x0000; a subsequent op 0x12x0x34 (mode=0) gives 0x03A8.
REQ-041 All scenarios above are repeated at WIDTH=16 with a randomized signed/unsigned sweep against a reference multiply, including the operands 0, 1, -1, minimum and maximum.
